mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the number of consecutive MEM grants allowed while IF waits, range 1..15.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port if_req, input, 1 bit: instruction-fetch read request (level).
REQ-005 SHALL have port if_addr, input, 32 bits: fetch address.
REQ-006 SHALL have port if_gnt, output, 1 bit: one-cycle pulse when the fetch request is accepted.
REQ-007 SHALL have port if_valid, output, 1 bit: one-cycle pulse when if_rdata is valid.
REQ-008 SHALL have port if_rdata, output, 32 bits: fetched word.
REQ-009 SHALL have ports mem_req (in, 1), mem_we (in, 1), mem_addr (in, 32), mem_wdata (in, 32): data-side request, write enable, address and write data.
REQ-010 SHALL have ports mem_gnt, mem_valid (out, 1) and mem_rdata (out, 32): the same meaning as the if_* outputs; mem_rdata is don't-care for writes.
REQ-011 SHALL have ports port_req, port_we (out, 1), port_addr, port_wdata (out, 32): the shared memory port.
REQ-012 SHALL have ports port_ack (in, 1) and port_rdata (in, 32): access-complete strobe and read data.
REQ-013 SHALL have port port_sel, output, 1 bit: 0 = IF owns the port, 1 = MEM owns it; it drives the select of the address mux2x32.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY_IF and BUSY_MEM.
REQ-015 SHALL arbitrate in IDLE: if mem_req is high and the guard is not tripped -> grant MEM; else if if_req is high -> grant IF; else stay in IDLE.
REQ-016 SHALL, on a grant, pulse the matching *_gnt in the arbitration cycle, capture addr/we/wdata at that edge and enter BUSY_x next cycle.
REQ-017 SHALL hold port_req high in BUSY_x with port_addr, port_we and port_wdata stable from the captured copy until port_ack; if_req is forced to read (port_we = 0).
REQ-018 SHALL hold port_sel at the owner's encoding in BUSY_x and keep its last value in IDLE.
REQ-019 SHALL respond to port_ack in BUSY_x by registering port_rdata and moving to IDLE; the next cycle pulses *_valid for exactly one cycle with *_rdata held until the next valid.
REQ-020 SHALL have minimum latency of req to valid = 3 cycles (grant, port cycle with ack at once, valid) and a one-cycle IDLE bubble between accesses.
REQ-021 SHALL ignore a requester's req in the cycle its *_valid is high (no regrant); the requester may update its address and re-request from the following cycle.
REQ-022 SHALL ignore port_ack in IDLE.
REQ-023 SHALL never assert if_gnt and mem_gnt in the same cycle, and SHALL never assert both valids in the same cycle.

Reset
REQ-024 SHALL, on reset asserted at any time, immediately set state = IDLE, all gnt/valid/port_req/port_we = 0, port_sel = 0, rdata/addr/wdata registers = 0 and starve count = 0; an in-flight access is abandoned with no valid.
REQ-025 SHALL resume arbitrating on the first rising clock edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro ARB_STARVE_GUARD_EN defined, run a starve counter: it increments on each MEM grant while if_req is high, clears on IF grant, and when it equals STARVE_MAX the guard trips so IF wins the next arbitration.
REQ-027 SHALL, with ARB_STARVE_GUARD_EN undefined, use strict MEM priority with no counter logic.

Structure
REQ-028 SHALL have package arb_pkg holding the FSM state encoding, SEL_IF = 1'b0 and SEL_MEM = 1'b1.
REQ-029 SHALL place the starve counter in sub-module arb_starve_cnt, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-030 SHALL cover: if_req with if_addr = 0x00400000, ack 2 cycles later with rdata = 0x24080005 -> if_gnt at cycle 0, port_req cycles 1-2, if_valid with that data at cycle 3.
REQ-031 SHALL cover: if_req and mem_req (we = 1, addr 0x10010000, wdata 0xDEADBEEF) in the same cycle -> mem_gnt first, port_we = 1, port_sel = 1, IF granted only after mem_valid.
REQ-032 SHALL cover, with ARB_STARVE_GUARD_EN and STARVE_MAX = 4: both requests held continuously -> 4 MEM grants then 1 IF grant, repeating; without the macro -> IF is never granted.
REQ-033 SHALL cover: reset pulsed during BUSY_MEM before ack -> outputs reach their reset values asynchronously; a later port_ack produces no valid.
REQ-034 SHALL cover: spurious port_ack in IDLE -> no valid and no state change; back-to-back IF requests -> exactly one grant per valid with no duplicate.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: FSM encoding,
// port-select encodings and the starve counter width.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } arb_state_t;

    localparam logic SEL_IF  = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // STARVE_MAX is limited to 1..15, so four bits hold every count value
    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive MEM grants taken while IF is waiting; trip tells the
// arbiter to let IF win the next arbitration.
module arb_starve_cnt
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic mem_grant,
    input  logic if_grant,
    input  logic if_req,
    output logic trip
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (if_grant) begin
            count_reg <= '0;
        end else if (mem_grant && if_req && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign trip = (count_reg == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port.
// Defining ARB_STARVE_GUARD_EN adds a guard that stops MEM starving IF.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        port_req,
    output logic        port_we,
    output logic [31:0] port_addr,
    output logic [31:0] port_wdata,
    input  logic        port_ack,
    input  logic [31:0] port_rdata,
    output logic        port_sel
);

    arb_state_t  state_reg, state_next;
    logic        sel_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] mem_rdata_reg;
    logic        if_valid_reg;
    logic        mem_valid_reg;
    logic        grant_if;
    logic        grant_mem;
    logic        starve_trip;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clock    (clock),
        .reset    (reset),
        .mem_grant(grant_mem),
        .if_grant (grant_if),
        .if_req   (if_req),
        .trip     (starve_trip)
    );
`else
    // Strict MEM priority: STARVE_MAX is 1..15, so this is constant zero
    assign starve_trip = (STARVE_MAX == 0);
`endif

    // The valid cycle is a bubble: no requester is regranted while a valid is out
    always_comb begin
        state_next = state_reg;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!reset && !if_valid_reg && !mem_valid_reg) begin
                    if (mem_req && !(starve_trip && if_req)) begin
                        grant_mem  = 1'b1;
                        state_next = BUSY_MEM;
                    end else if (if_req) begin
                        grant_if   = 1'b1;
                        state_next = BUSY_IF;
                    end
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (port_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sel_reg       <= SEL_IF;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            if_valid_reg  <= 1'b0;
            mem_valid_reg <= 1'b0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            if_valid_reg  <= (state_reg == BUSY_IF) && port_ack;
            mem_valid_reg <= (state_reg == BUSY_MEM) && port_ack;
            if (grant_mem) begin
                sel_reg   <= SEL_MEM;
                we_reg    <= mem_we;
                addr_reg  <= mem_addr;
                wdata_reg <= mem_wdata;
            end else if (grant_if) begin
                sel_reg   <= SEL_IF;
                we_reg    <= 1'b0;
                addr_reg  <= if_addr;
                wdata_reg <= '0;
            end
            if ((state_reg == BUSY_IF) && port_ack) begin
                if_rdata_reg <= port_rdata;
            end
            if ((state_reg == BUSY_MEM) && port_ack) begin
                mem_rdata_reg <= port_rdata;
            end
        end
    end

    assign if_gnt     = grant_if;
    assign mem_gnt    = grant_mem;
    assign if_valid   = if_valid_reg;
    assign mem_valid  = mem_valid_reg;
    assign if_rdata   = if_rdata_reg;
    assign mem_rdata  = mem_rdata_reg;
    assign port_req   = (state_reg != IDLE);
    assign port_we    = port_req && we_reg;
    assign port_addr  = addr_reg;
    assign port_wdata = wdata_reg;
    assign port_sel   = sel_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the starvation scenario
// follows whether ARB_STARVE_GUARD_EN is defined for the build.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_gnt, mem_valid;
    logic [31:0] mem_rdata;
    logic        port_req, port_we, port_sel;
    logic [31:0] port_addr, port_wdata;
    logic        port_ack = 1'b0;
    logic [31:0] port_rdata = '0;

    int cmp_count = 0;
    int err_count = 0;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .port_req  (port_req),
        .port_we   (port_we),
        .port_addr (port_addr),
        .port_wdata(port_wdata),
        .port_ack  (port_ack),
        .port_rdata(port_rdata),
        .port_sel  (port_sel)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later
    task automatic cycle_start();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        port_ack = 1'b0;
        if_req = 1'b0;
        mem_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cycle_start();
        if_req = 1'b1;
        mem_req = 1'b1;
        settle();
        cmp_count++; if (if_gnt !== 1'b0) begin err_count++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
        cmp_count++; if (mem_gnt !== 1'b0) begin err_count++; $display("FAIL rst_mem_gnt: got %b want 0", mem_gnt); end
        cmp_count++; if (port_req !== 1'b0) begin err_count++; $display("FAIL rst_port_req: got %b want 0", port_req); end
        cmp_count++; if (port_we !== 1'b0) begin err_count++; $display("FAIL rst_port_we: got %b want 0", port_we); end
        cmp_count++; if (port_sel !== 1'b0) begin err_count++; $display("FAIL rst_port_sel: got %b want 0", port_sel); end
        cmp_count++; if (port_addr !== 32'h0) begin err_count++; $display("FAIL rst_port_addr: got %h want 0", port_addr); end
        cmp_count++; if (port_wdata !== 32'h0) begin err_count++; $display("FAIL rst_port_wdata: got %h want 0", port_wdata); end
        cmp_count++; if ({if_valid, mem_valid} !== 2'b00) begin err_count++; $display("FAIL rst_valids: got %b want 00", {if_valid, mem_valid}); end
        cmp_count++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin err_count++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, mem_rdata); end
        if_req = 1'b0;
        mem_req = 1'b0;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_if_read();
        cycle_start();
        if_req = 1'b1;
        if_addr = 32'h0040_0000;
        settle();
        cmp_count++; if (if_gnt !== 1'b1) begin err_count++; $display("FAIL if_read_gnt: got %b want 1", if_gnt); end
        cmp_count++; if (mem_gnt !== 1'b0) begin err_count++; $display("FAIL if_read_mem_gnt: got %b want 0", mem_gnt); end
        cmp_count++; if (port_req !== 1'b0) begin err_count++; $display("FAIL if_read_req_c0: got %b want 0", port_req); end
        cycle_start();
        if_req = 1'b0;
        settle();
        cmp_count++; if (port_req !== 1'b1) begin err_count++; $display("FAIL if_read_req_c1: got %b want 1", port_req); end
        cmp_count++; if (port_addr !== 32'h0040_0000) begin err_count++; $display("FAIL if_read_addr: got %h want 00400000", port_addr); end
        cmp_count++; if ({port_we, port_sel} !== 2'b00) begin err_count++; $display("FAIL if_read_we_sel: got %b want 00", {port_we, port_sel}); end
        cmp_count++; if (if_gnt !== 1'b0) begin err_count++; $display("FAIL if_read_regrant: got %b want 0", if_gnt); end
        cycle_start();
        port_ack = 1'b1;
        port_rdata = 32'h2408_0005;
        settle();
        cmp_count++; if (port_req !== 1'b1) begin err_count++; $display("FAIL if_read_req_c2: got %b want 1", port_req); end
        cmp_count++; if (if_valid !== 1'b0) begin err_count++; $display("FAIL if_read_early_valid: got %b want 0", if_valid); end
        cycle_start();
        port_ack = 1'b0;
        port_rdata = 32'h0;
        settle();
        cmp_count++; if (if_valid !== 1'b1) begin err_count++; $display("FAIL if_read_valid: got %b want 1", if_valid); end
        cmp_count++; if (if_rdata !== 32'h2408_0005) begin err_count++; $display("FAIL if_read_rdata: got %h want 24080005", if_rdata); end
        cmp_count++; if ({mem_valid, port_req} !== 2'b00) begin err_count++; $display("FAIL if_read_c3_idle: got %b want 00", {mem_valid, port_req}); end
        cycle_start();
        settle();
        cmp_count++; if (if_valid !== 1'b0) begin err_count++; $display("FAIL if_read_valid_pulse: got %b want 0", if_valid); end
        cmp_count++; if (if_rdata !== 32'h2408_0005) begin err_count++; $display("FAIL if_read_rdata_hold: got %h want 24080005", if_rdata); end
        $display("test_if_read done");
    endtask

    task automatic test_priority();
        cycle_start();
        if_req = 1'b1;
        if_addr = 32'h0040_0004;
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h1001_0000;
        mem_wdata = 32'hDEAD_BEEF;
        settle();
        cmp_count++; if ({mem_gnt, if_gnt} !== 2'b10) begin err_count++; $display("FAIL prio_gnt: got mem/if %b want 10", {mem_gnt, if_gnt}); end
        cycle_start();
        mem_req = 1'b0;
        mem_we = 1'b0;
        port_ack = 1'b1;
        settle();
        cmp_count++; if ({port_req, port_we, port_sel} !== 3'b111) begin err_count++; $display("FAIL prio_port_ctl: got %b want 111", {port_req, port_we, port_sel}); end
        cmp_count++; if (port_addr !== 32'h1001_0000) begin err_count++; $display("FAIL prio_addr: got %h want 10010000", port_addr); end
        cmp_count++; if (port_wdata !== 32'hDEAD_BEEF) begin err_count++; $display("FAIL prio_wdata: got %h want deadbeef", port_wdata); end
        cmp_count++; if (if_gnt !== 1'b0) begin err_count++; $display("FAIL prio_if_busy: got %b want 0", if_gnt); end
        cycle_start();
        port_ack = 1'b0;
        settle();
        cmp_count++; if ({mem_valid, if_valid, if_gnt} !== 3'b100) begin err_count++; $display("FAIL prio_mem_valid: got %b want 100", {mem_valid, if_valid, if_gnt}); end
        cycle_start();
        settle();
        cmp_count++; if ({if_gnt, mem_gnt} !== 2'b10) begin err_count++; $display("FAIL prio_if_after: got if/mem %b want 10", {if_gnt, mem_gnt}); end
        cmp_count++; if (port_sel !== 1'b1) begin err_count++; $display("FAIL prio_sel_hold: got %b want 1", port_sel); end
        cycle_start();
        if_req = 1'b0;
        port_ack = 1'b1;
        port_rdata = 32'h8C42_0000;
        settle();
        cmp_count++; if ({port_req, port_we, port_sel} !== 3'b100) begin err_count++; $display("FAIL prio_if_port: got %b want 100", {port_req, port_we, port_sel}); end
        cmp_count++; if (port_addr !== 32'h0040_0004) begin err_count++; $display("FAIL prio_if_addr: got %h want 00400004", port_addr); end
        cycle_start();
        port_ack = 1'b0;
        settle();
        cmp_count++; if ({if_valid, mem_valid} !== 2'b10) begin err_count++; $display("FAIL prio_if_valid: got %b want 10", {if_valid, mem_valid}); end
        cmp_count++; if (if_rdata !== 32'h8C42_0000) begin err_count++; $display("FAIL prio_if_rdata: got %h want 8c420000", if_rdata); end
        $display("test_priority done");
    endtask

    task automatic test_starve();
        int  grants;
        bit  both_seen;
        logic exp_mem;
        do_reset();
        grants = 0;
        both_seen = 1'b0;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            cycle_start();
            mem_req = 1'b1;
            mem_we = 1'b0;
            mem_addr = 32'h1001_0010;
            if_req = 1'b1;
            if_addr = 32'h0040_0000;
            port_ack = port_req;
            port_rdata = 32'h5000_0000 + 32'(c);
            settle();
            if ((if_gnt && mem_gnt) || (if_valid && mem_valid)) both_seen = 1'b1;
            if (if_gnt || mem_gnt) begin
`ifdef ARB_STARVE_GUARD_EN
                exp_mem = ((grants % 5) != 4);
`else
                exp_mem = 1'b1;
`endif
                cmp_count++;
                if (mem_gnt !== exp_mem || if_gnt !== !exp_mem) begin
                    err_count++;
                    $display("FAIL starve_grant%0d: got mem/if %b%b want %b%b", grants, mem_gnt, if_gnt, exp_mem, !exp_mem);
                end
                $display("starve grant %0d: mem=%b if=%b", grants, mem_gnt, if_gnt);
                grants++;
            end
        end
        cmp_count++; if (grants != 10) begin err_count++; $display("FAIL starve_bound: got %0d grants want 10", grants); end
        cmp_count++; if (both_seen) begin err_count++; $display("FAIL starve_exclusive: got overlap want none"); end
        mem_req = 1'b0;
        if_req = 1'b0;
        port_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle_start();
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h1001_0008;
        mem_wdata = 32'h1234_5678;
        settle();
        cmp_count++; if (mem_gnt !== 1'b1) begin err_count++; $display("FAIL rmid_gnt: got %b want 1", mem_gnt); end
        cycle_start();
        mem_req = 1'b0;
        mem_we = 1'b0;
        settle();
        cmp_count++; if ({port_req, port_sel, port_we} !== 3'b111) begin err_count++; $display("FAIL rmid_busy: got %b want 111", {port_req, port_sel, port_we}); end
        #1;
        reset = 1'b1;
        #1;
        cmp_count++; if ({port_req, port_sel, port_we} !== 3'b000) begin err_count++; $display("FAIL rmid_async_ctl: got %b want 000", {port_req, port_sel, port_we}); end
        cmp_count++; if (port_addr !== 32'h0 || port_wdata !== 32'h0) begin err_count++; $display("FAIL rmid_async_data: got %h/%h want 0/0", port_addr, port_wdata); end
        cycle_start();
        reset = 1'b0;
        cycle_start();
        port_ack = 1'b1;
        port_rdata = 32'hBAD0_BAD0;
        cycle_start();
        port_ack = 1'b0;
        settle();
        cmp_count++; if ({mem_valid, if_valid} !== 2'b00) begin err_count++; $display("FAIL rmid_no_valid: got %b want 00", {mem_valid, if_valid}); end
        cmp_count++; if (mem_rdata !== 32'h0) begin err_count++; $display("FAIL rmid_rdata: got %h want 0", mem_rdata); end
        $display("test_reset_mid done");
    endtask

    task automatic test_spurious_ack();
        cycle_start();
        port_ack = 1'b1;
        port_rdata = 32'hCAFE_F00D;
        settle();
        cmp_count++; if (port_req !== 1'b0) begin err_count++; $display("FAIL spur_req_c0: got %b want 0", port_req); end
        cycle_start();
        port_ack = 1'b0;
        settle();
        cmp_count++; if ({if_valid, mem_valid, port_req} !== 3'b000) begin err_count++; $display("FAIL spur_state: got %b want 000", {if_valid, mem_valid, port_req}); end
        cmp_count++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin err_count++; $display("FAIL spur_rdata: got %h/%h want 0/0", if_rdata, mem_rdata); end
        $display("test_spurious_ack done");
    endtask

    task automatic test_back_to_back();
        logic exp_gnt, exp_valid;
        for (int k = 0; k < 12; k++) begin
            cycle_start();
            if_req = 1'b1;
            if_addr = 32'h0040_0000 + 32'(4 * k);
            port_ack = port_req;
            port_rdata = 32'h0000_0100 + 32'(k);
            settle();
            exp_gnt = ((k % 3) == 0);
            exp_valid = ((k % 3) == 2);
            cmp_count++; if (if_gnt !== exp_gnt) begin err_count++; $display("FAIL b2b_gnt c%0d: got %b want %b", k, if_gnt, exp_gnt); end
            cmp_count++; if (if_valid !== exp_valid) begin err_count++; $display("FAIL b2b_valid c%0d: got %b want %b", k, if_valid, exp_valid); end
            if (exp_valid) begin
                cmp_count++; if (if_rdata !== 32'h0000_0100 + 32'(k - 1)) begin err_count++; $display("FAIL b2b_rdata c%0d: got %h want %h", k, if_rdata, 32'h0000_0100 + 32'(k - 1)); end
            end
        end
        if_req = 1'b0;
        port_ack = 1'b0;
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_priority();
        test_starve();
        test_reset_mid();
        test_spurious_ack();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
